if_id_fifo: RTL and testbench
=============================

Name: if_id_fifo

Overview:
Parametrised successor of the single-entry fetch/decode pipeline register. It holds a DEPTH-entry circular queue of fetch packets (PC, instruction, branch-prediction bit, BTB target). Fetch and decode connect through valid/ready handshakes, so fetch can run ahead of a stalled decode. A flush discards every queued packet on a control-hazard redirect.

Parameters:
DEPTH, 4, number of queue entries; power of two, >= 2
ADDR_W, `MEM_ADDR_WIDTH, PC width
INST_W, `REG_DATA_WIDTH, instruction width
TGT_W, 32, BTB target width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  discard all queued packets (mispredict redirect)
if_valid  in  1  fetch presents a packet
if_ready  out  1  queue can accept a packet
PC_if  in  ADDR_W  fetch PC
inst_if  in  INST_W  fetched instruction
bp_if  in  1  predicted-taken bit
BTB_target_if  in  TGT_W  predicted target
id_valid  out  1  head packet valid for decode
id_ready  in  1  decode consumes head (deasserted on load/branch stall)
PC_id  out  ADDR_W  head PC
inst_id  out  INST_W  head instruction
bp_id  out  1  head prediction bit
BTB_target_id  out  TGT_W  head BTB target
count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, id_valid=0, if_ready=1. Storage contents are not reset.
- push = if_valid & if_ready. pop = id_valid & id_ready.
- if_ready = (count != DEPTH). It depends on registered state only. There is no combinational path from id_ready.
- id_valid = (count != 0).
- Head outputs are read combinationally from entry[rd_ptr], gated by id_valid.
  - When id_valid=0: inst_id=0 (NOP bubble), bp_id=0, BTB_target_id=0, PC_id=0.
- Latency: a packet pushed at edge N appears on the id_* outputs after edge N. There is no same-cycle bypass.
- Per edge, without flush:
  - push writes entry[wr_ptr] and increments wr_ptr modulo DEPTH.
  - pop increments rd_ptr modulo DEPTH.
  - count += push - pop.
- Simultaneous push and pop:
  - Allowed at any occupancy 1..DEPTH-1: count is unchanged.
  - When full, if_ready=0, so no push occurs; pop alone proceeds.
  - When empty, pop cannot occur; push alone proceeds.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Flush has priority over push and pop in the same cycle.
  - Next state: wr_ptr=0, rd_ptr=0, count=0, id_valid=0.
  - The packet offered on the flush cycle is dropped.
  - if_ready=1 on the following cycle.
- Hold: with id_ready=0 and no flush, head outputs stay stable indefinitely.
- Reset asserted mid-operation clears state immediately, regardless of clk, flush or handshakes.
- Protocol requirement on the fetch side: fetch keeps if_valid and its data stable while if_ready=0. Verification asserts this as an assumption.

Decomposition:
- A shared package (defines.sv) holds:
  - a packed struct if_id_pkt_t {pc, inst, bp, btb_target};
  - the NOP encoding constant;
  - width macros.
- Storage is an array of if_id_pkt_t.
- One natural sub-module is fifo_ptr_ctrl: pointers, count, full/empty and flush logic. It is reusable for later ID/EX queues.
- Storage and output gating stay in if_id_fifo.

Test Plan:
1. Reset, then push PC=0x100, inst=0x00500093 with id_ready=0. Required: after the next edge id_valid=1, PC_id=0x100, inst_id=0x00500093, count=1. Before that edge id_valid=0 and inst_id=0.
2. DEPTH=4, push 5 packets (PC 0x0,0x4,0x8,0xC,0x10) with id_ready=0. Required: if_ready=0 after the 4th, count=4, and the 5th is held by fetch. Then id_ready=1 pops 0x0,0x4,0x8,0xC,0x10 in order.
3. Steady stream: push and pop every cycle for 10 cycles with PC 0x200+4k. Required: count stays 1, each PC appears on PC_id exactly once and in order across pointer wrap.
4. With 3 entries queued, assert flush together with if_valid (PC=0x300) and id_ready=1. Required: next cycle count=0, id_valid=0, inst_id=0, bp_id=0, if_ready=1, and PC 0x300 never appears.
5. Push a packet with bp_if=1, BTB_target_if=0x80, hold id_ready=0 for 5 cycles, then pop. Required: bp_id=1 and BTB_target_id=0x80 stable throughout, and the packet is popped exactly once.
6. Assert rst asynchronously between clock edges with 2 entries queued. Required: id_valid=0 and count=0 immediately, before any clk edge.

Source files
------------

// File: rtl/if_id_fifo_pkg.sv
// Shared types and width constants for the fetch/decode packet queue.
// The ID/EX queues are expected to reuse these definitions later.
package if_id_fifo_pkg;

  localparam int MEM_ADDR_WIDTH = 32;
  localparam int REG_DATA_WIDTH = 32;
  localparam int BTB_TGT_WIDTH  = 32;

  // An all-zero word is the bubble that decode treats as a NOP
  localparam logic [REG_DATA_WIDTH-1:0] NOP_INST = '0;

  typedef struct packed {
    logic [MEM_ADDR_WIDTH-1:0] pc;
    logic [REG_DATA_WIDTH-1:0] inst;
    logic                      bp;
    logic [BTB_TGT_WIDTH-1:0]  btb_target;
  } if_id_pkt_t;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Circular-queue bookkeeping: read/write pointers, occupancy, full/empty and flush.
// Holds no payload, so any packet queue can pair it with its own storage.
module fifo_ptr_ctrl #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_req,
  input  logic             rd_req,
  output logic             wr_en,
  output logic             rd_en,
  output logic             full,
  output logic             empty,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count
);

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Flush wins: a packet offered or consumed on the flush cycle is discarded
  assign wr_en = wr_req & ~full  & ~flush;
  assign rd_en = rd_req & ~empty & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_id_fifo.sv
// DEPTH-entry fetch/decode packet queue; lets fetch run ahead of a stalled decode.
// Head packet is read combinationally and replaced by an all-zero bubble when empty.
module if_id_fifo
  import if_id_fifo_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int ADDR_W = MEM_ADDR_WIDTH,
  parameter  int INST_W = REG_DATA_WIDTH,
  parameter  int TGT_W  = BTB_TGT_WIDTH,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] PC_if,
  input  logic [INST_W-1:0] inst_if,
  input  logic              bp_if,
  input  logic [TGT_W-1:0]  BTB_target_if,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] PC_id,
  output logic [INST_W-1:0] inst_id,
  output logic              bp_id,
  output logic [TGT_W-1:0]  BTB_target_id,
  output logic [CNT_W-1:0]  count
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
  // if_ready and id_valid come from registered occupancy only, never from the
  // other side's valid/ready, and a producer must hold valid+data until accepted.

  logic             wr_en;
  logic             rd_en;
  logic             full;
  logic             empty;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  if_id_pkt_t mem [DEPTH];
  if_id_pkt_t wr_pkt;
  if_id_pkt_t head;

  fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .wr_req (if_valid),
    .rd_req (id_ready),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .full   (full),
    .empty  (empty),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (count)
  );

  assign if_ready = ~full;
  assign id_valid = ~empty;

  always_comb begin
    wr_pkt            = '0;
    wr_pkt.pc         = PC_if;
    wr_pkt.inst       = inst_if;
    wr_pkt.bp         = bp_if;
    wr_pkt.btb_target = BTB_target_if;
  end

  // Payload storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_pkt;
  end

  assign head = mem[rd_ptr];

  always_comb begin
    PC_id         = '0;
    inst_id       = NOP_INST;
    bp_id         = 1'b0;
    BTB_target_id = '0;
    if (id_valid) begin
      PC_id         = head.pc;
      inst_id       = head.inst;
      bp_id         = head.bp;
      BTB_target_id = head.btb_target;
    end
  end

  // rd_en is consumed inside the controller; kept here for probing pops
  logic unused_rd_en;
  assign unused_rd_en = rd_en;

endmodule

// File: tb/tb_if_id_fifo.sv
// Directed bench for if_id_fifo (DEPTH=4): reset, fill/hold, streaming, flush,
// prediction-field hold and asynchronous reset.
module tb_if_id_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] PC_if;
  logic [31:0] inst_if;
  logic        bp_if;
  logic [31:0] BTB_target_if;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] PC_id;
  logic [31:0] inst_id;
  logic        bp_id;
  logic [31:0] BTB_target_id;
  logic [2:0]  count;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  if_id_fifo #(.DEPTH(4), .ADDR_W(32), .INST_W(32), .TGT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .PC_if         (PC_if),
    .inst_if       (inst_if),
    .bp_if         (bp_if),
    .BTB_target_if (BTB_target_if),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .PC_id         (PC_id),
    .inst_id       (inst_id),
    .bp_id         (bp_id),
    .BTB_target_id (BTB_target_id),
    .count         (count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    PC_if = '0; inst_if = '0; bp_if = 1'b0; BTB_target_if = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid: got %b expected 0", id_valid); end
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_cmp++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL reset_if_ready: got %b expected 1", if_ready); end
    n_cmp++; if (inst_id !== 32'h0) begin n_fail++; $display("FAIL reset_inst_id: got %h expected 0", inst_id); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    if_valid = 1'b1; PC_if = 32'h100; inst_if = 32'h00500093; id_ready = 1'b0;
    #1;
    n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL single_pre_valid: got %b expected 0", id_valid); end
    n_cmp++; if (inst_id !== 32'h0) begin n_fail++; $display("FAIL single_pre_inst: got %h expected 0", inst_id); end
    tick();
    if_valid = 1'b0;
    n_cmp++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", id_valid); end
    n_cmp++; if (PC_id !== 32'h100) begin n_fail++; $display("FAIL single_pc: got %h expected 100", PC_id); end
    n_cmp++; if (inst_id !== 32'h00500093) begin n_fail++; $display("FAIL single_inst: got %h expected 00500093", inst_id); end
    n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", count); end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_drain: got %0d expected 0", count); end
  endtask

  task automatic test_fill();
    id_ready = 1'b0;
    exp_q = {32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    for (int k = 0; k < 4; k++) begin
      if_valid = 1'b1; PC_if = 32'(4 * k); inst_if = 32'(k + 1);
      tick();
      n_cmp++; if (count !== 3'(k + 1)) begin n_fail++; $display("FAIL fill_count%0d: got %0d expected %0d", k, count, k + 1); end
    end
    n_cmp++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready: got %b expected 0", if_ready); end
    PC_if = 32'h10; inst_if = 32'h5;
    repeat (2) tick();
    n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_held_count: got %0d expected 4", count); end
    n_cmp++; if (PC_id !== 32'h0) begin n_fail++; $display("FAIL fill_held_head: got %h expected 0", PC_id); end
    id_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic accept;
      n_cmp++; if (PC_id !== exp_q[i]) begin n_fail++; $display("FAIL fill_pop%0d: got %h expected %h", i, PC_id, exp_q[i]); end
      accept = if_valid & if_ready;
      tick();
      if (accept) if_valid = 1'b0;
    end
    id_ready = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL fill_empty: got %0d expected 0", count); end
    n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL fill_fifth_taken: fetch still waiting, expected accepted"); end
  endtask

  task automatic test_stream();
    if_valid = 1'b1; PC_if = 32'h200; id_ready = 1'b0;
    tick();
    for (int k = 1; k <= 10; k++) begin
      PC_if = 32'h200 + 32'(4 * k); id_ready = 1'b1;
      #1;
      n_cmp++; if (PC_id !== 32'h200 + 32'(4 * (k - 1))) begin n_fail++; $display("FAIL stream_pc%0d: got %h expected %h", k, PC_id, 32'h200 + 32'(4 * (k - 1))); end
      n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL stream_count%0d: got %0d expected 1", k, count); end
      tick();
    end
    if_valid = 1'b0;
    n_cmp++; if (PC_id !== 32'h228) begin n_fail++; $display("FAIL stream_last: got %h expected 228", PC_id); end
    tick();
    id_ready = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL stream_drain: got %0d expected 0", count); end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      if_valid = 1'b1; PC_if = 32'h40 + 32'(4 * k); inst_if = 32'h77; bp_if = 1'b1;
      tick();
    end
    n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count: got %0d expected 3", count); end
    flush = 1'b1; PC_if = 32'h300; inst_if = 32'h1234; id_ready = 1'b1;
    tick();
    flush = 1'b0; if_valid = 1'b0; bp_if = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", count); end
    n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", id_valid); end
    n_cmp++; if (inst_id !== 32'h0) begin n_fail++; $display("FAIL flush_inst: got %h expected 0", inst_id); end
    n_cmp++; if (bp_id !== 1'b0) begin n_fail++; $display("FAIL flush_bp: got %b expected 0", bp_id); end
    n_cmp++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b expected 1", if_ready); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (id_valid !== 1'b0 || PC_id === 32'h300) begin n_fail++; $display("FAIL flush_dropped%0d: valid %b pc %h expected valid 0", k, id_valid, PC_id); end
    end
    id_ready = 1'b0;
  endtask

  task automatic test_hold();
    if_valid = 1'b1; PC_if = 32'h500; inst_if = 32'hABC; bp_if = 1'b1; BTB_target_if = 32'h80; id_ready = 1'b0;
    tick();
    if_valid = 1'b0; bp_if = 1'b0; BTB_target_if = '0;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (bp_id !== 1'b1) begin n_fail++; $display("FAIL hold_bp%0d: got %b expected 1", k, bp_id); end
      n_cmp++; if (BTB_target_id !== 32'h80) begin n_fail++; $display("FAIL hold_btb%0d: got %h expected 80", k, BTB_target_id); end
      n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL hold_count%0d: got %0d expected 1", k, count); end
      tick();
    end
    id_ready = 1'b1;
    n_cmp++; if (PC_id !== 32'h500) begin n_fail++; $display("FAIL hold_pc: got %h expected 500", PC_id); end
    tick();
    id_ready = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL hold_popped_once: got %0d expected 0", count); end
    n_cmp++; if (bp_id !== 1'b0 || BTB_target_id !== 32'h0) begin n_fail++; $display("FAIL hold_bubble: bp %b btb %h expected 0/0", bp_id, BTB_target_id); end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 2; k++) begin
      if_valid = 1'b1; PC_if = 32'h600 + 32'(4 * k);
      tick();
    end
    if_valid = 1'b0;
    n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL arst_pre_count: got %0d expected 2", count); end
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b expected 0", id_valid); end
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL arst_count: got %0d expected 0", count); end
    n_cmp++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %b expected 1", if_ready); end
    #1;
    rst = 1'b0;
    tick();
    n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL arst_after: got %b expected 0", id_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_flush();
    test_hold();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
